// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, IF/ID register, 16-entry 2-bit branch predictor
// and a RUN/HALT state machine that stops fetch after a halt opcode until redirected.
module fetch_unit (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        flush,
  input  logic [7:0]  redirect_pc,
  input  logic        update,
  input  logic        actual_taken,
  input  logic [7:0]  resolve_pc,
  input  logic [15:0] imem_data,
  output logic [7:0]  imem_addr,
  output logic [15:0] instruction_IF,
  output logic [7:0]  pc_ID,
  output logic        valid_ID,
  output logic        predict_taken,
  output logic        halt
);

  localparam int unsigned PC_W    = 8;
  localparam int unsigned INSTR_W = 16;
  localparam int unsigned IDX_W   = 4;
  localparam int unsigned NUM_CTR = 16;
  localparam int unsigned CTR_W   = 2;

  localparam logic [3:0] OP_BRANCH = 4'hC;
  localparam logic [3:0] OP_JUMP   = 4'hD;
  localparam logic [3:0] OP_HALT   = 4'hF;

  localparam logic [CTR_W-1:0] CTR_INIT = 2'b01;
  localparam logic [CTR_W-1:0] CTR_MAX  = 2'b11;
  localparam logic [CTR_W-1:0] CTR_MIN  = 2'b00;

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HALT = 1'b1;

  logic [0:0]         r_state;
  logic [PC_W-1:0]    r_pc;
  logic [INSTR_W-1:0] r_instr;
  logic [PC_W-1:0]    r_pc_id;
  logic               r_valid;
  logic               r_pred;
  logic [CTR_W-1:0]   r_ctr [NUM_CTR];

  logic [0:0]         w_state_nxt;
  logic [PC_W-1:0]    w_pc_nxt;
  logic               w_load;
  logic               w_pred_nxt;
  logic [3:0]         w_opcode;
  logic [PC_W-1:0]    w_target;
  logic               w_ctr_taken;
  logic [IDX_W-1:0]   w_upd_idx;
  logic [CTR_W-1:0]   w_ctr_cur;
  logic [CTR_W-1:0]   w_ctr_upd;
  logic               w_unused_ok;

  assign w_opcode    = imem_data[15:12];
  assign w_target    = imem_data[11:4];
  assign w_ctr_taken = r_ctr[r_pc[IDX_W-1:0]][CTR_W-1];
  assign w_upd_idx   = resolve_pc[IDX_W-1:0];
  assign w_ctr_cur   = r_ctr[w_upd_idx];
  assign w_unused_ok = ^resolve_pc[PC_W-1:IDX_W];

  // Next-state / next-PC selection; flush beats stall beats HALT
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_load      = 1'b0;
    w_pred_nxt  = 1'b0;
    if (flush) begin
      w_state_nxt = ST_RUN;
      w_pc_nxt    = redirect_pc;
    end else if (!stall && (r_state == ST_RUN)) begin
      w_load = 1'b1;
      if (w_opcode == OP_JUMP) begin
        w_pc_nxt   = w_target;
        w_pred_nxt = 1'b1;
      end else if ((w_opcode == OP_BRANCH) && w_ctr_taken) begin
        w_pc_nxt   = w_target;
        w_pred_nxt = 1'b1;
      end else begin
        w_pc_nxt = PC_W'(r_pc + PC_W'(1));
      end
      if (w_opcode == OP_HALT) begin
        w_state_nxt = ST_HALT;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // PC and IF/ID register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pc    <= '0;
      r_instr <= '0;
      r_pc_id <= '0;
      r_valid <= 1'b0;
      r_pred  <= 1'b0;
    end else begin
      r_pc <= w_pc_nxt;
      if (flush) begin
        r_instr <= '0;
        r_valid <= 1'b0;
        r_pred  <= 1'b0;
      end else if (w_load) begin
        r_instr <= imem_data;
        r_pc_id <= r_pc;
        r_valid <= 1'b1;
        r_pred  <= w_pred_nxt;
      end
    end
  end

  // Saturating counter update; a same-cycle lookup sees the old value
  always_comb begin
    w_ctr_upd = w_ctr_cur;
    if (actual_taken) begin
      if (w_ctr_cur != CTR_MAX) w_ctr_upd = CTR_W'(w_ctr_cur + CTR_W'(1));
    end else begin
      if (w_ctr_cur != CTR_MIN) w_ctr_upd = CTR_W'(w_ctr_cur - CTR_W'(1));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NUM_CTR; i++) begin
        r_ctr[i] <= CTR_INIT;
      end
    end else if (update) begin
      r_ctr[w_upd_idx] <= w_ctr_upd;
    end
  end

  assign imem_addr      = r_pc;
  assign instruction_IF = r_instr;
  assign pc_ID          = r_pc_id;
  assign valid_ID       = r_valid;
  assign predict_taken  = r_pred;
  assign halt           = (r_state == ST_HALT);

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: expected IF-stage state is queued per driven cycle
// and compared one edge later; reset behaviour is checked directly.
module tb_fetch_unit;

  logic        clk;
  logic        reset_n;
  logic        stall;
  logic        flush;
  logic [7:0]  redirect_pc;
  logic        update;
  logic        actual_taken;
  logic [7:0]  resolve_pc;
  logic [15:0] imem_data;
  logic [7:0]  imem_addr;
  logic [15:0] instruction_IF;
  logic [7:0]  pc_ID;
  logic        valid_ID;
  logic        predict_taken;
  logic        halt;

  logic [15:0] mem [256];

  typedef struct packed {
    logic [7:0]  addr;
    logic [15:0] instr;
    logic [7:0]  pcid;
    logic        valid;
    logic        pred;
    logic        halt;
  } obs_t;

  obs_t exp_q [$];
  int   n_total = 0;
  int   n_bad   = 0;

  fetch_unit dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .stall          (stall),
    .flush          (flush),
    .redirect_pc    (redirect_pc),
    .update         (update),
    .actual_taken   (actual_taken),
    .resolve_pc     (resolve_pc),
    .imem_data      (imem_data),
    .imem_addr      (imem_addr),
    .instruction_IF (instruction_IF),
    .pc_ID          (pc_ID),
    .valid_ID       (valid_ID),
    .predict_taken  (predict_taken),
    .halt           (halt)
  );

  assign imem_data = mem[imem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic obs_t mk(input logic [7:0] a, input logic [15:0] i, input logic [7:0] p,
                              input logic v, input logic pr, input logic h);
    obs_t o;
    o.addr = a; o.instr = i; o.pcid = p; o.valid = v; o.pred = pr; o.halt = h;
    return o;
  endfunction

  task automatic check_reset(input string tag);
    chk({tag, "/addr"},  32'(imem_addr), 32'h00);
    chk({tag, "/instr"}, 32'(instruction_IF), 32'h0000);
    chk({tag, "/pcid"},  32'(pc_ID), 32'h00);
    chk({tag, "/valid"}, 32'(valid_ID), 32'h0);
    chk({tag, "/pred"},  32'(predict_taken), 32'h0);
    chk({tag, "/halt"},  32'(halt), 32'h0);
  endtask

  // Drive one cycle of inputs, queue the expectation, compare after the edge
  task automatic cyc(input string tag, input logic st, input logic fl, input logic [7:0] rpc,
                     input logic up, input logic at, input logic [7:0] rspc, input obs_t e);
    obs_t x;
    stall = st; flush = fl; redirect_pc = rpc;
    update = up; actual_taken = at; resolve_pc = rspc;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    x = exp_q.pop_front();
    chk({tag, "/addr"},  32'(imem_addr), 32'(x.addr));
    chk({tag, "/instr"}, 32'(instruction_IF), 32'(x.instr));
    chk({tag, "/pcid"},  32'(pc_ID), 32'(x.pcid));
    chk({tag, "/valid"}, 32'(valid_ID), 32'(x.valid));
    chk({tag, "/pred"},  32'(predict_taken), 32'(x.pred));
    chk({tag, "/halt"},  32'(halt), 32'(x.halt));
  endtask

  task automatic idle(input string tag, input obs_t e);
    cyc(tag, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, e);
  endtask

  task automatic redirect(input string tag, input logic [7:0] rpc, input obs_t e);
    cyc(tag, 1'b0, 1'b1, rpc, 1'b0, 1'b0, 8'h00, e);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h1000 | 16'(i);
    mem[5] = 16'hC2A0;
    mem[6] = 16'hD300;
    mem[7] = 16'hF000;

    reset_n = 1'b0; stall = 1'b0; flush = 1'b0; redirect_pc = 8'h00;
    update = 1'b0; actual_taken = 1'b0; resolve_pc = 8'h00;
    #3;
    check_reset("rst");
    @(negedge clk);
    reset_n = 1'b1;

    // sequential fetch with one-cycle IF/ID lag
    idle("seq0", mk(8'h01, 16'h1000, 8'h00, 1, 0, 0));
    idle("seq1", mk(8'h02, 16'h1001, 8'h01, 1, 0, 0));
    idle("seq2", mk(8'h03, 16'h1002, 8'h02, 1, 0, 0));
    idle("seq3", mk(8'h04, 16'h1003, 8'h03, 1, 0, 0));

    // train entry 5 while stalled, then predict the branch at 0x05
    cyc("trn0", 1, 0, 8'h00, 1, 1, 8'h05, mk(8'h04, 16'h1003, 8'h03, 1, 0, 0));
    cyc("trn1", 1, 0, 8'h00, 1, 1, 8'h05, mk(8'h04, 16'h1003, 8'h03, 1, 0, 0));
    redirect("fl5a", 8'h05, mk(8'h05, 16'h0000, 8'h03, 0, 0, 0));
    idle("br_tk", mk(8'h2A, 16'hC2A0, 8'h05, 1, 1, 0));
    cyc("sat_hi", 0, 0, 8'h00, 1, 1, 8'h05, mk(8'h2B, 16'h102A, 8'h2A, 1, 0, 0));
    cyc("fl5b", 0, 1, 8'h05, 1, 0, 8'h05, mk(8'h05, 16'h0000, 8'h2A, 0, 0, 0));
    cyc("rd_upd", 0, 0, 8'h00, 1, 0, 8'h05, mk(8'h2A, 16'hC2A0, 8'h05, 1, 1, 0));
    redirect("fl5c", 8'h05, mk(8'h05, 16'h0000, 8'h05, 0, 0, 0));
    idle("br_nt", mk(8'h06, 16'hC2A0, 8'h05, 1, 0, 0));
    idle("jump", mk(8'h30, 16'hD300, 8'h06, 1, 1, 0));

    // flush wins over a simultaneous stall
    cyc("fl_st", 1, 1, 8'h40, 0, 0, 8'h00, mk(8'h40, 16'h0000, 8'h06, 0, 0, 0));
    idle("aft40", mk(8'h41, 16'h1040, 8'h40, 1, 0, 0));

    // halt holds fetch until a flush
    redirect("fl7", 8'h07, mk(8'h07, 16'h0000, 8'h40, 0, 0, 0));
    idle("halt", mk(8'h08, 16'hF000, 8'h07, 1, 0, 1));
    for (int i = 0; i < 10; i++) idle("hhold", mk(8'h08, 16'hF000, 8'h07, 1, 0, 1));
    cyc("hstall", 1, 0, 8'h00, 0, 0, 8'h00, mk(8'h08, 16'hF000, 8'h07, 1, 0, 1));
    redirect("unhalt", 8'h10, mk(8'h10, 16'h0000, 8'h07, 0, 0, 0));
    idle("resume", mk(8'h11, 16'h1010, 8'h10, 1, 0, 0));

    // PC wraps from FF to 00
    redirect("flFF", 8'hFF, mk(8'hFF, 16'h0000, 8'h10, 0, 0, 0));
    idle("wrap", mk(8'h00, 16'h10FF, 8'hFF, 1, 0, 0));
    idle("wrap1", mk(8'h01, 16'h1000, 8'h00, 1, 0, 0));

    // train during HALT, then reset mid-cycle
    redirect("fl7b", 8'h07, mk(8'h07, 16'h0000, 8'h00, 0, 0, 0));
    idle("halt2", mk(8'h08, 16'hF000, 8'h07, 1, 0, 1));
    cyc("htrn0", 0, 0, 8'h00, 1, 1, 8'h05, mk(8'h08, 16'hF000, 8'h07, 1, 0, 1));
    cyc("htrn1", 0, 0, 8'h00, 1, 1, 8'h05, mk(8'h08, 16'hF000, 8'h07, 1, 0, 1));
    update = 1'b0;
    #3;
    reset_n = 1'b0;
    #1;
    check_reset("mid_rst");
    #1;
    reset_n = 1'b1;
    idle("post0", mk(8'h01, 16'h1000, 8'h00, 1, 0, 0));
    redirect("fl5d", 8'h05, mk(8'h05, 16'h0000, 8'h00, 0, 0, 0));
    idle("ctr_rst", mk(8'h06, 16'hC2A0, 8'h05, 1, 0, 0));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 reset_n  in  1  asynchronous, active-low reset; assertion clears state immediately, deassertion synchronous to clk.
REQ-003 stall  in  1  hazard hold; freezes PC and IF/ID register.
REQ-004 flush  in  1  misprediction/redirect from EX; squashes IF/ID, loads PC from redirect_pc.
REQ-005 redirect_pc  in  8  correct next PC on flush.
REQ-006 update  in  1  branch resolved in EX this cycle; train predictor.
REQ-007 actual_taken  in  1  resolved direction of the branch being trained.
REQ-008 resolve_pc  in  8  PC of the resolved branch.
REQ-009 imem_data  in  16  instruction at imem_addr, combinational read.
REQ-010 imem_addr  out  8  current PC.
REQ-011 instruction_IF  out  16  IF/ID instruction register.
REQ-012 pc_ID  out  8  PC of instruction_IF.
REQ-013 valid_ID  out  1  instruction_IF is a real instruction (0 = bubble).
REQ-014 predict_taken  out  1  prediction made for instruction_IF.
REQ-015 halt  out  1  fetch halted.

Function
REQ-016 Opcode is instr[15:12]: 4'hC conditional branch, 4'hD jump, 4'hF halt; branch/jump target is instr[11:4], absolute 8-bit.
REQ-017 Predictor: 16 x 2-bit saturating counters indexed by PC[3:0]; taken iff counter >= 2'b10.
REQ-018 Next-PC priority, highest first: flush -> redirect_pc; stall -> hold; HALT state -> hold; fetched jump -> target; fetched branch predicted taken -> target; otherwise PC+1, wrapping 8'hFF -> 8'h00.
REQ-019 IF/ID load, no stall/flush/HALT: instruction_IF <= imem_data, pc_ID <= PC, valid_ID <= 1, predict_taken <= 1 for jump, counter-taken for branch, else 0.
REQ-020 Flush: instruction_IF <= 16'h0000, valid_ID <= 0, predict_taken <= 0, in the same edge the PC loads redirect_pc; flush overrides stall and HALT.
REQ-021 Stall without flush: PC, instruction_IF, pc_ID, valid_ID, predict_taken unchanged.
REQ-022 FSM states RUN, HALT; RUN -> HALT when halt opcode loaded into IF/ID; HALT -> RUN only on flush (halt on wrong path); halt = (state == HALT).
REQ-023 In HALT, IF/ID keeps the halt instruction, valid_ID stays 1, PC frozen at halt PC+1.
REQ-024 Training on update: counter[resolve_pc[3:0]] increments if actual_taken, else decrements, saturating at 2'b11 and 2'b00.
REQ-025 Training is independent of stall/flush/HALT.
REQ-026 Same-cycle read and update of one entry: prediction uses pre-update value; new value visible next cycle.
REQ-027 Latency: instruction at imem_addr in cycle N appears on instruction_IF after edge N+1; taken prediction redirects fetch with zero bubbles.

Reset
REQ-028 reset_n low: PC = 8'h00, instruction_IF = 16'h0000, pc_ID = 8'h00, valid_ID = 0, predict_taken = 0, halt = 0, state RUN, all counters = 2'b01 (weakly not-taken).
REQ-029 Reset mid-operation aborts any in-flight fetch or HALT with no residual state; first fetch after deassertion is from 8'h00.

Verification
REQ-030 Sequential: memory 0x00..0x03 non-branch, no stall -> imem_addr 00,01,02,03; instruction_IF lags one cycle; valid_ID = 1 from second edge.
REQ-031 Training: 2x update, resolve_pc = 8'h05, actual_taken = 1, then fetch 16'hC2A0 at 0x05 -> predict_taken = 1, next imem_addr = 8'h2A; third taken update keeps counter 2'b11.
REQ-032 Flush+stall same edge, redirect_pc = 8'h40 -> imem_addr = 8'h40, valid_ID = 0, instruction_IF = 16'h0000.
REQ-033 Halt 16'hF000 at 0x07 -> halt = 1 after edge, imem_addr held at 8'h08 for 10 cycles; flush to 8'h10 -> halt = 0, fetch resumes at 8'h10.
REQ-034 Wrap: PC = 8'hFF non-branch -> next imem_addr = 8'h00.
REQ-035 reset_n pulsed low mid-cycle during HALT -> all outputs at reset values before the next clock edge.
